ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter sharing the single-port 1024x16 data RAM between the CPU (requester 0) and a secondary master such as a DMA or debug loader (requester 1).
- Sits between both masters and the RAM instance.
- Default is fixed priority to the CPU. A starvation counter guarantees requester 1 a slot.
- Either master can lock the RAM for atomic multi-cycle sequences, for example call/push.

Parameters:
STARVE_LIMIT, 4, consecutive denied cycles of m1 after which m1 wins the next arbitration; legal range 1..15

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  CPU access request, level, sampled each cycle
m0_write  input  1  1 = write, 0 = read
m0_lock  input  1  hold ownership after this access
m0_addr  input  10  word address
m0_din  input  16  write data
m0_gnt  output  1  access accepted this cycle (combinational)
m0_rvalid  output  1  read data valid (registered)
m0_rdata  output  16  read data
m1_req, m1_write, m1_lock, m1_addr, m1_din, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for requester 1
ram_addr  output  10  RAM address
ram_write  output  1  RAM write enable
ram_din  output  16  RAM write data
ram_dout  input  16  RAM read data, one-cycle registered read latency

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State is ARB, starve_cnt = 0.
  - m0_rvalid = m1_rvalid = 0.
  - With no request, m0_gnt = m1_gnt = 0, ram_write = 0, ram_addr = 0, ram_din = 0.
- States:
  - ARB: normal arbitration.
  - LOCK0: m0 owns the RAM exclusively.
  - LOCK1: m1 owns the RAM exclusively.
- ARB winner selection:
  - m1 wins if m1_req and starve_cnt == STARVE_LIMIT.
  - Otherwise m0 wins if m0_req.
  - Otherwise m1 wins if m1_req.
  - Otherwise no grant.
- LOCK0: only m0 may be granted; m1_gnt = 0 regardless of starve_cnt.
- LOCK1: only m1 may be granted; m0_gnt = 0.
- Grant is combinational, asserted in the same cycle as req, and at most one gnt is high per cycle.
- The winner's addr/write/din drive the RAM. With no grant, ram_write = 0 and ram_addr/ram_din = 0.
- Writes: committed at the clock edge ending the grant cycle; no rvalid is produced.
- Reads:
  - mX_rvalid = 1 for exactly one cycle, the cycle after a granted read by mX.
  - mX_rdata = ram_dout whenever mX_rvalid = 1, else 0.
  - Back-to-back granted reads give back-to-back rvalid.
- Transitions:
  - ARB -> LOCK0 when m0 is granted with m0_lock = 1; ARB -> LOCK1 likewise for m1.
  - LOCKx -> ARB at the end of a cycle where mx_req = 1 and mx_lock = 0; that access is still granted.
  - LOCKx with mx_req = 0 stays locked (no timeout), and no grants are issued.
- starve_cnt, width 4:
  - Increments, saturating at STARVE_LIMIT, when m1_req = 1 and m1_gnt = 0.
  - Clears to 0 when m1_gnt = 1 or m1_req = 0.
  - Counts during LOCK0 but cannot preempt it; m1 wins the first ARB cycle after the lock releases if saturated.
- Boundaries:
  - Addresses pass unchanged; 0x3FF is legal, with no wrap logic here.
  - m0 write and m1 read to the same address in the same cycle: m0 wins. m1 reads the new data when granted later.
  - m0 and m1 both requesting with starve_cnt saturated and m1_lock = 1: m1 is granted and the state enters LOCK1.
- Reset mid-operation: a pending rvalid is dropped (0 after reset), any lock is cleared, and the counter is zeroed.

Test Plan:
- Idle: no req for 10 cycles -> both gnt and rvalid = 0, ram_write = 0, ram_addr = 0.
- RAM[0x005] = 0xBEEF; m1 alone reads 0x005 -> m1_gnt in cycle 0, m1_rvalid = 1 with m1_rdata = 0xBEEF in cycle 1, m0_rvalid stays 0.
- STARVE_LIMIT = 4; m0 and m1 both request reads continuously:
  - m0_gnt in cycles 0-3, m1_gnt in cycle 4.
  - m0_gnt in cycles 5-8, m1_gnt in cycle 9.
  - Each rvalid follows its grant by 1 cycle.
- Cycle 0: m0 writes 0x1234 to 0x3FF while m1 reads 0x3FF -> m0_gnt = 1 and m1_gnt = 0 in cycle 0, m1_gnt in cycle 1, m1_rvalid = 1 with m1_rdata = 0x1234 in cycle 2.
- Lock sequence:
  - m1 read with m1_lock = 1 in cycle 0; m0_req high in cycles 1-4.
  - m1 accesses cycles 1-2 with lock = 1, then cycle 3 with lock = 0.
  - Expected: m0_gnt = 0 in cycles 0-3, m0_gnt = 1 in cycle 4.
- m0 read granted in cycle 0; rst_n pulled low mid cycle 1 -> m0_rvalid = 0 immediately, all outputs at reset values. After release, m1 wins a contested cycle only after 4 further denied cycles.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port 1024x16 data RAM between the CPU
// (requester 0) and a secondary master (requester 1). The CPU has fixed
// priority, a saturating starvation counter guarantees requester 1 a slot,
// and either master may lock the RAM across an atomic multi-cycle sequence.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic        m0_lock,
    input  logic [9:0]  m0_addr,
    input  logic [15:0] m0_din,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic        m1_lock,
    input  logic [9:0]  m1_addr,
    input  logic [15:0] m1_din,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [15:0] m1_rdata,
    output logic [9:0]  ram_addr,
    output logic        ram_write,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout
);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_nxt_s;
    logic        m0_gnt_s;
    logic        m1_gnt_s;
    logic        m0_rvalid_r;
    logic        m1_rvalid_r;

    // Grant selection: starved m1 first, then CPU, then m1; locks exclude the other side.
    always_comb begin
        m0_gnt_s = 1'b0;
        m1_gnt_s = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (m1_req && (starve_cnt_r == LIMIT_C)) begin
                    m1_gnt_s = 1'b1;
                end else if (m0_req) begin
                    m0_gnt_s = 1'b1;
                end else if (m1_req) begin
                    m1_gnt_s = 1'b1;
                end else begin
                    m0_gnt_s = 1'b0;
                    m1_gnt_s = 1'b0;
                end
            end
            ST_LOCK0: begin
                m0_gnt_s = m0_req;
            end
            ST_LOCK1: begin
                m1_gnt_s = m1_req;
            end
            default: begin
                m0_gnt_s = 1'b0;
                m1_gnt_s = 1'b0;
            end
        endcase
    end

    // RAM port mux: the granted master drives the RAM, otherwise the port idles at zero.
    always_comb begin
        if (m0_gnt_s) begin
            ram_addr  = m0_addr;
            ram_write = m0_write;
            ram_din   = m0_din;
        end else if (m1_gnt_s) begin
            ram_addr  = m1_addr;
            ram_write = m1_write;
            ram_din   = m1_din;
        end else begin
            ram_addr  = 10'd0;
            ram_write = 1'b0;
            ram_din   = 16'd0;
        end
    end

    // Next lock state: enter on a locked grant, leave on an unlocked access by the owner.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARB: begin
                if (m0_gnt_s && m0_lock) begin
                    state_nxt_s = ST_LOCK0;
                end else if (m1_gnt_s && m1_lock) begin
                    state_nxt_s = ST_LOCK1;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_LOCK0: begin
                if (m0_req && !m0_lock) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_LOCK0;
                end
            end
            ST_LOCK1: begin
                if (m1_req && !m1_lock) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_LOCK1;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // Starvation count: saturating count of consecutive denied m1 requests.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (!m1_req || m1_gnt_s) begin
            starve_nxt_s = 4'd0;
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // State, counter and read-valid registers; reset drops any pending read and lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_ARB;
            starve_cnt_r <= 4'd0;
            m0_rvalid_r  <= 1'b0;
            m1_rvalid_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            m0_rvalid_r  <= m0_gnt_s && !m0_write;
            m1_rvalid_r  <= m1_gnt_s && !m1_write;
        end
    end

    // Read data is routed only to the master whose read returns this cycle.
    always_comb begin
        if (m0_rvalid_r) begin
            m0_rdata = ram_dout;
        end else begin
            m0_rdata = 16'd0;
        end
        if (m1_rvalid_r) begin
            m1_rdata = ram_dout;
        end else begin
            m1_rdata = 16'd0;
        end
    end

    assign m0_gnt    = m0_gnt_s;
    assign m1_gnt    = m1_gnt_s;
    assign m0_rvalid = m0_rvalid_r;
    assign m1_rvalid = m1_rvalid_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Table-driven bench for ram_arbiter with a behavioural 1024x16 RAM
// (one-cycle registered read) attached to the RAM port.
module tb_ram_arbiter;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [9:0]  Z   = 10'h000;
    localparam logic [15:0] N   = 16'h0000;
    localparam logic [15:0] RD0 = 16'h5A5A;
    localparam logic [15:0] RD1 = 16'hC3C3;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_write, m0_lock;
    logic [9:0]  m0_addr;
    logic [15:0] m0_din;
    logic        m0_gnt, m0_rvalid;
    logic [15:0] m0_rdata;
    logic        m1_req, m1_write, m1_lock;
    logic [9:0]  m1_addr;
    logic [15:0] m1_din;
    logic        m1_gnt, m1_rvalid;
    logic [15:0] m1_rdata;
    logic [9:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic [15:0] mem [0:1023];

    int n_vec;
    int n_err;

    typedef struct {
        logic r0, w0, l0; logic [9:0] a0; logic [15:0] d0;
        logic r1, w1, l1; logic [9:0] a1; logic [15:0] d1;
        logic g0, g1, v0, v1; logic [15:0] rd0, rd1;
    } vec_t;

    vec_t q[$];

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write at the edge, registered read of the current address.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    function automatic logic [15:0] pat(input logic [9:0] a);
        return 16'hA000 | {6'd0, a};
    endfunction

    function automatic vec_t v(
        input logic r0, w0, l0, input logic [9:0] a0, input logic [15:0] d0,
        input logic r1, w1, l1, input logic [9:0] a1, input logic [15:0] d1,
        input logic g0, g1, v0, v1, input logic [15:0] rd0, rd1);
        vec_t t;
        t.r0 = r0; t.w0 = w0; t.l0 = l0; t.a0 = a0; t.d0 = d0;
        t.r1 = r1; t.w1 = w1; t.l1 = l1; t.a1 = a1; t.d1 = d1;
        t.g0 = g0; t.g1 = g1; t.v0 = v0; t.v1 = v1; t.rd0 = rd0; t.rd1 = rd1;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        m0_req = t.r0; m0_write = t.w0; m0_lock = t.l0; m0_addr = t.a0; m0_din = t.d0;
        m1_req = t.r1; m1_write = t.w1; m1_lock = t.l1; m1_addr = t.a1; m1_din = t.d1;
    endtask

    task automatic check_vec(input vec_t t, input int idx);
        logic [9:0]  ea;
        logic        ew;
        logic [15:0] ed;
        ea = t.g0 ? t.a0 : (t.g1 ? t.a1 : 10'd0);
        ew = t.g0 ? t.w0 : (t.g1 ? t.w1 : 1'b0);
        ed = t.g0 ? t.d0 : (t.g1 ? t.d1 : 16'd0);
        n_vec++;
        chk("m0_gnt",    idx, {15'd0, m0_gnt},    {15'd0, t.g0});
        chk("m1_gnt",    idx, {15'd0, m1_gnt},    {15'd0, t.g1});
        chk("m0_rvalid", idx, {15'd0, m0_rvalid}, {15'd0, t.v0});
        chk("m1_rvalid", idx, {15'd0, m1_rvalid}, {15'd0, t.v1});
        chk("m0_rdata",  idx, m0_rdata, t.rd0);
        chk("m1_rdata",  idx, m1_rdata, t.rd1);
        chk("ram_write", idx, {15'd0, ram_write}, {15'd0, ew});
        chk("ram_addr",  idx, {6'd0, ram_addr},   {6'd0, ea});
        chk("ram_din",   idx, ram_din, ed);
    endtask

    task automatic run_vectors();
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            check_vec(q[i], i);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    vec_t idle_t;

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
        mem[10'h005] = 16'hBEEF;
        idle_t = v(F,F,F,Z,N, F,F,F,Z,N, F,F,F,F,N,N);
        drive(idle_t);
        rst_n = 1'b0;
        #12;
        check_vec(idle_t, -1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle for ten cycles.
        for (int i = 0; i < 10; i++) q.push_back(idle_t);
        // m1 alone reads 0x005.
        q.push_back(v(F,F,F,Z,N, T,F,F,10'h005,RD1, F,T, F,F,N,N));
        q.push_back(v(F,F,F,Z,N, F,F,F,Z,N,        F,F, F,T,N,16'hBEEF));
        // Continuous contention: m1 every fifth cycle.
        for (int c = 0; c < 10; c++) begin
            logic g1c, pg0, pg1;
            g1c = (c == 4) || (c == 9);
            pg0 = (c >= 1) && (c != 5);
            pg1 = (c == 5);
            q.push_back(v(T,F,F,10'h010,RD0, T,F,F,10'h020,RD1, !g1c, g1c, pg0, pg1,
                          pg0 ? pat(10'h010) : N, pg1 ? pat(10'h020) : N));
        end
        q.push_back(v(F,F,F,Z,N, F,F,F,Z,N, F,F, F,T,N,pat(10'h020)));
        // Same address: m0 write beats m1 read, m1 later reads the new data.
        q.push_back(v(T,T,F,10'h3FF,16'h1234, T,F,F,10'h3FF,RD1, T,F, F,F,N,N));
        q.push_back(v(F,F,F,Z,N,              T,F,F,10'h3FF,RD1, F,T, F,F,N,N));
        q.push_back(v(F,F,F,Z,N,              F,F,F,Z,N,         F,F, F,T,N,16'h1234));
        // m1 lock sequence holds off m0.
        q.push_back(v(F,F,F,Z,N,          T,F,T,10'h005,RD1, F,T, F,F,N,N));
        q.push_back(v(T,F,F,10'h100,RD0,  T,F,T,10'h006,RD1, F,T, F,T,N,16'hBEEF));
        q.push_back(v(T,F,F,10'h100,RD0,  T,F,T,10'h007,RD1, F,T, F,T,N,pat(10'h006)));
        q.push_back(v(T,F,F,10'h100,RD0,  T,F,F,10'h008,RD1, F,T, F,T,N,pat(10'h007)));
        q.push_back(v(T,F,F,10'h100,RD0,  F,F,F,Z,N,         T,F, F,T,N,pat(10'h008)));
        q.push_back(v(F,F,F,Z,N,          F,F,F,Z,N,         F,F, T,F,pat(10'h100),N));
        // m0 lock: counter saturates but cannot preempt; idle lock issues no grants.
        q.push_back(v(T,F,T,10'h011,RD0, T,F,F,10'h021,RD1, T,F, F,F,N,N));
        q.push_back(v(F,F,F,Z,N,         T,F,F,10'h021,RD1, F,F, T,F,pat(10'h011),N));
        q.push_back(v(F,F,F,Z,N,         T,F,F,10'h021,RD1, F,F, F,F,N,N));
        q.push_back(v(T,F,T,10'h012,RD0, T,F,F,10'h021,RD1, T,F, F,F,N,N));
        q.push_back(v(T,F,F,10'h013,RD0, T,F,F,10'h021,RD1, T,F, T,F,pat(10'h012),N));
        q.push_back(v(T,F,F,10'h014,RD0, T,F,F,10'h021,RD1, F,T, T,F,pat(10'h013),N));
        q.push_back(v(F,F,F,Z,N,         F,F,F,Z,N,         F,F, F,T,N,pat(10'h021)));
        // Saturated counter with m1_lock: m1 granted and takes the lock.
        for (int c = 0; c < 4; c++)
            q.push_back(v(T,F,F,10'h010,RD0, T,F,F,10'h020,RD1, T,F, (c >= 1), F,
                          (c >= 1) ? pat(10'h010) : N, N));
        q.push_back(v(T,F,F,10'h010,RD0, T,F,T,10'h020,RD1, F,T, T,F,pat(10'h010),N));
        q.push_back(v(T,F,F,10'h010,RD0, F,F,F,Z,N,         F,F, F,T,N,pat(10'h020)));
        q.push_back(v(T,F,F,10'h010,RD0, T,F,F,10'h022,RD1, F,T, F,F,N,N));
        q.push_back(v(T,F,F,10'h010,RD0, F,F,F,Z,N,         T,F, F,T,N,pat(10'h022)));
        q.push_back(v(F,F,F,Z,N,         F,F,F,Z,N,         F,F, T,F,pat(10'h010),N));
        run_vectors();

        // Reset mid-operation: locked m0 read pending, counter at 1.
        drive(v(T,F,T,10'h005,RD0, T,F,F,10'h020,RD1, F,F,F,F,N,N));
        @(negedge clk);
        n_vec++;
        chk("pre_rst_m0_gnt", 0, {15'd0, m0_gnt}, 16'd1);
        chk("pre_rst_m1_gnt", 0, {15'd0, m1_gnt}, 16'd0);
        @(posedge clk);
        #1;
        drive(idle_t);
        n_vec++;
        chk("pre_rst_m0_rvalid", 1, {15'd0, m0_rvalid}, 16'd1);
        chk("pre_rst_m0_rdata",  1, m0_rdata, 16'hBEEF);
        rst_n = 1'b0;
        #1;
        check_vec(idle_t, -2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After reset: lock cleared, counter restarted, m1 wins on the fifth contested cycle.
        for (int c = 0; c < 5; c++)
            q.push_back(v(T,F,F,10'h030,RD0, T,F,F,10'h040,RD1, (c != 4), (c == 4), (c >= 1), F,
                          (c >= 1) ? pat(10'h030) : N, N));
        q.push_back(v(F,F,F,Z,N, F,F,F,Z,N, F,F, F,T,N,pat(10'h040)));
        run_vectors();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
